// File: rtl/spu_issue_pkg.sv
// Shared types for the SPU dual-issue stage: issue packet layout and pipe select.
package spu_issue_pkg;

  localparam int PKT_W    = 126;
  localparam int NUM_REGS = 128;
  localparam int LAT_W    = 4;
  localparam int REG_W    = 7;

  localparam int INSTR_W  = 32;
  localparam int ID_W     = 7;
  localparam int UNIT_W   = 3;
  localparam int IMM7_W   = 7;
  localparam int IMM10_W  = 10;
  localparam int IMM16_W  = 16;
  localparam int IMM18_W  = 18;

  typedef struct packed {
    logic [INSTR_W-1:0] full_instr;
    logic [ID_W-1:0]    instr_id;
    logic [REG_W-1:0]   reg_dst;
    logic [UNIT_W-1:0]  unit_id;
    logic [LAT_W-1:0]   latency;
    logic               reg_wr;
    logic [IMM7_W-1:0]  imme7;
    logic [IMM10_W-1:0] imme10;
    logic [IMM16_W-1:0] imme16;
    logic [IMM18_W-1:0] imme18;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [REG_W-1:0]   rc;
  } issue_pkt_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } pipe_sel_t;

endpackage

// File: rtl/spu_scoreboard.sv
// Per-register latency countdown: counters load on issue and count down to zero.
// Ready means the counter reads zero this cycle; busy is registered with the counters.
module spu_scoreboard
  import spu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_even_en,
  input  logic [REG_W-1:0] ld_even_reg,
  input  logic [LAT_W-1:0] ld_even_lat,
  input  logic             ld_odd_en,
  input  logic [REG_W-1:0] ld_odd_reg,
  input  logic [LAT_W-1:0] ld_odd_lat,
  input  logic [REG_W-1:0] src_reg [6],
  output logic [5:0]       src_rdy,
  input  logic [REG_W-1:0] dst_reg [2],
  output logic [1:0]       dst_rdy,
  output logic             busy
);

  logic [LAT_W-1:0] cnt     [NUM_REGS];
  logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
  logic             any_nz;

  // A load overrides the decrement; the issue logic never loads one register from both ports.
  always_comb begin
    any_nz = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - 1'b1 : cnt[r];
      if (ld_even_en && ld_even_reg == REG_W'(r)) cnt_nxt[r] = ld_even_lat;
      if (ld_odd_en && ld_odd_reg == REG_W'(r))   cnt_nxt[r] = ld_odd_lat;
      any_nz = any_nz | (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= any_nz;
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_src
    assign src_rdy[i] = (cnt[src_reg[i]] == '0);
  end

  for (genvar i = 0; i < 2; i++) begin : g_dst
    assign dst_rdy[i] = (cnt[dst_reg[i]] == '0);
  end

endmodule

// File: rtl/spu_issue_ctrl.sv
// Dual in-order issue: hazard-checks two decoded instructions and steers them to even/odd pipes.
// in_consume is combinational; issued packets appear registered one cycle later.
module spu_issue_ctrl
  import spu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [PKT_W-1:0] in0_pkt,
  input  logic             in0_pipe,
  input  logic [2:0]       in0_src_use,
  input  logic             in1_valid,
  input  logic [PKT_W-1:0] in1_pkt,
  input  logic             in1_pipe,
  input  logic [2:0]       in1_src_use,
  input  logic             flush,
  output logic [1:0]       in_consume,
  output logic             even_valid,
  output logic [PKT_W-1:0] even_pkt,
  output logic             odd_valid,
  output logic [PKT_W-1:0] odd_pkt,
  output logic             sb_busy
);

  issue_pkt_t       p0, p1;
  logic [REG_W-1:0] src_reg [6];
  logic [REG_W-1:0] dst_reg [2];
  logic [5:0]       src_rdy;
  logic [1:0]       dst_rdy;
  logic             ok0, ok1, raw01, waw01, issue0, issue1;
  logic             even_sel_vld, odd_sel_vld;
  issue_pkt_t       even_sel, odd_sel;

  assign p0 = issue_pkt_t'(in0_pkt);
  assign p1 = issue_pkt_t'(in1_pkt);

  assign src_reg[0] = p0.ra;
  assign src_reg[1] = p0.rb;
  assign src_reg[2] = p0.rc;
  assign src_reg[3] = p1.ra;
  assign src_reg[4] = p1.rb;
  assign src_reg[5] = p1.rc;
  assign dst_reg[0] = p0.reg_dst;
  assign dst_reg[1] = p1.reg_dst;

  assign ok0 = (&(src_rdy[2:0] | ~in0_src_use)) & (~p0.reg_wr | dst_rdy[0]);
  assign ok1 = (&(src_rdy[5:3] | ~in1_src_use)) & (~p1.reg_wr | dst_rdy[1]);

  // in1 cannot see in0's result in the same cycle, nor share its destination.
  assign raw01 = p0.reg_wr & ((in1_src_use[0] & (p1.ra == p0.reg_dst)) |
                              (in1_src_use[1] & (p1.rb == p0.reg_dst)) |
                              (in1_src_use[2] & (p1.rc == p0.reg_dst)));
  assign waw01 = p0.reg_wr & p1.reg_wr & (p0.reg_dst == p1.reg_dst);

  assign issue0 = ~rst & ~flush & in0_valid & ok0;
  assign issue1 = issue0 & in1_valid & (in1_pipe != in0_pipe) & ok1 & ~raw01 & ~waw01;
  assign in_consume = {1'b0, issue0} + {1'b0, issue1};

  // Pipes always differ when both issue, so the two steering writes never collide.
  always_comb begin
    even_sel_vld = 1'b0;
    odd_sel_vld  = 1'b0;
    even_sel     = '0;
    odd_sel      = '0;
    if (issue0) begin
      if (pipe_sel_t'(in0_pipe) == ODD) begin
        odd_sel_vld = 1'b1;
        odd_sel     = p0;
      end else begin
        even_sel_vld = 1'b1;
        even_sel     = p0;
      end
    end
    if (issue1) begin
      if (pipe_sel_t'(in1_pipe) == ODD) begin
        odd_sel_vld = 1'b1;
        odd_sel     = p1;
      end else begin
        even_sel_vld = 1'b1;
        even_sel     = p1;
      end
    end
  end

  spu_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .ld_even_en  (even_sel_vld & even_sel.reg_wr & (even_sel.latency != '0)),
    .ld_even_reg (even_sel.reg_dst),
    .ld_even_lat (even_sel.latency),
    .ld_odd_en   (odd_sel_vld & odd_sel.reg_wr & (odd_sel.latency != '0)),
    .ld_odd_reg  (odd_sel.reg_dst),
    .ld_odd_lat  (odd_sel.latency),
    .src_reg     (src_reg),
    .src_rdy     (src_rdy),
    .dst_reg     (dst_reg),
    .dst_rdy     (dst_rdy),
    .busy        (sb_busy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      even_valid <= 1'b0;
      even_pkt   <= '0;
      odd_valid  <= 1'b0;
      odd_pkt    <= '0;
    end else begin
      even_valid <= even_sel_vld;
      even_pkt   <= even_sel;
      odd_valid  <= odd_sel_vld;
      odd_pkt    <= odd_sel;
    end
  end

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Random-stimulus bench for spu_issue_ctrl; the reference tracks, per register, the
// cycle at which its pending result becomes readable, and models the decoder as a queue.
module tb_spu_issue_ctrl;
  import spu_issue_pkg::*;

  typedef struct {
    issue_pkt_t pkt;
    logic       pipe;
    logic [2:0] srcs;
  } instr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid, in0_pipe, in1_pipe, flush;
  logic [PKT_W-1:0] in0_pkt, in1_pkt;
  logic [2:0]       in0_src_use, in1_src_use;
  logic [1:0]       in_consume;
  logic             even_valid, odd_valid, sb_busy;
  logic [PKT_W-1:0] even_pkt, odd_pkt;

  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;
  int     rdy_cyc [NUM_REGS];
  instr_t q[$];

  always #5 clk = ~clk;

  spu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in0_valid   (in0_valid),
    .in0_pkt     (in0_pkt),
    .in0_pipe    (in0_pipe),
    .in0_src_use (in0_src_use),
    .in1_valid   (in1_valid),
    .in1_pkt     (in1_pkt),
    .in1_pipe    (in1_pipe),
    .in1_src_use (in1_src_use),
    .flush       (flush),
    .in_consume  (in_consume),
    .even_valid  (even_valid),
    .even_pkt    (even_pkt),
    .odd_valid   (odd_valid),
    .odd_pkt     (odd_pkt),
    .sb_busy     (sb_busy)
  );

  task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit reg_ok(input logic [REG_W-1:0] r);
    return cyc >= rdy_cyc[r];
  endfunction

  function automatic bit can_issue(input instr_t i);
    bit ok = 1'b1;
    if (i.srcs[0] && !reg_ok(i.pkt.ra)) ok = 1'b0;
    if (i.srcs[1] && !reg_ok(i.pkt.rb)) ok = 1'b0;
    if (i.srcs[2] && !reg_ok(i.pkt.rc)) ok = 1'b0;
    if (i.pkt.reg_wr && !reg_ok(i.pkt.reg_dst)) ok = 1'b0;
    return ok;
  endfunction

  function automatic bit reads_reg(input instr_t i, input logic [REG_W-1:0] r);
    return (i.srcs[0] && i.pkt.ra == r) || (i.srcs[1] && i.pkt.rb == r) ||
           (i.srcs[2] && i.pkt.rc == r);
  endfunction

  function automatic logic [REG_W-1:0] rnd_reg();
    return ($urandom_range(0, 9) == 0) ? REG_W'($urandom_range(0, 127)) : REG_W'($urandom_range(0, 7));
  endfunction

  function automatic instr_t mk(input logic pipe, input int dst, input int ra, input int rb,
                                input logic [2:0] srcs, input int lat, input logic wr);
    instr_t i;
    i.pkt            = '0;
    i.pkt.full_instr = $urandom;
    i.pkt.instr_id   = ID_W'($urandom);
    i.pkt.unit_id    = UNIT_W'($urandom);
    i.pkt.imme7      = IMM7_W'($urandom);
    i.pkt.imme10     = IMM10_W'($urandom);
    i.pkt.imme16     = IMM16_W'($urandom);
    i.pkt.imme18     = IMM18_W'($urandom);
    i.pkt.rc         = REG_W'($urandom_range(0, 7));
    i.pkt.reg_dst    = REG_W'(dst);
    i.pkt.ra         = REG_W'(ra);
    i.pkt.rb         = REG_W'(rb);
    i.pkt.latency    = LAT_W'(lat);
    i.pkt.reg_wr     = wr;
    i.pipe           = pipe;
    i.srcs           = srcs;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i = mk(1'($urandom), int'(rnd_reg()), int'(rnd_reg()), int'(rnd_reg()),
                   3'($urandom), int'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0));
    i.pkt.rc = rnd_reg();
    return i;
  endfunction

  initial begin
    instr_t     i0, i1;
    bit         e0, e1;
    logic       ev_v, od_v;
    issue_pkt_t ev_p, od_p;
    bit         busy_exp;

    for (int r = 0; r < NUM_REGS; r++) rdy_cyc[r] = 0;
    // Directed openers: dual issue, intra-pair RAW, same-pipe conflict, WAW reload.
    q.push_back(mk(EVEN, 1, 2, 3, 3'b011, 2, 1'b1));
    q.push_back(mk(ODD,  4, 5, 0, 3'b001, 6, 1'b1));
    q.push_back(mk(EVEN, 20, 0, 0, 3'b000, 3, 1'b1));
    q.push_back(mk(ODD,  9, 20, 0, 3'b001, 1, 1'b1));
    q.push_back(mk(EVEN, 10, 11, 12, 3'b011, 1, 1'b1));
    q.push_back(mk(EVEN, 13, 14, 0, 3'b001, 1, 1'b1));
    q.push_back(mk(ODD,  7, 0, 0, 3'b000, 4, 1'b1));
    q.push_back(mk(EVEN, 7, 0, 0, 3'b000, 2, 1'b1));

    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      while (q.size() < 2) q.push_back(rand_instr());
      i0          = q[0];
      i1          = q[1];
      rst         = (k < 3) || ($urandom_range(0, 49) == 0);
      flush       = !rst && ($urandom_range(0, 12) == 0);
      in0_valid   = (k < 3) || ($urandom_range(0, 9) != 0);
      in1_valid   = in0_valid && ((k < 3) || ($urandom_range(0, 6) != 0));
      in0_pkt     = i0.pkt;
      in0_pipe    = i0.pipe;
      in0_src_use = i0.srcs;
      in1_pkt     = i1.pkt;
      in1_pipe    = i1.pipe;
      in1_src_use = i1.srcs;
      #1;

      e0 = !rst && !flush && in0_valid && can_issue(i0);
      e1 = e0 && in1_valid && (i1.pipe != i0.pipe) && can_issue(i1) &&
           !(i0.pkt.reg_wr && reads_reg(i1, i0.pkt.reg_dst)) &&
           !(i0.pkt.reg_wr && i1.pkt.reg_wr && i0.pkt.reg_dst == i1.pkt.reg_dst);
      chk("in_consume", in_consume, e0 + e1);

      ev_v = 1'b0; od_v = 1'b0; ev_p = '0; od_p = '0;
      if (e0) begin
        if (i0.pipe) begin od_v = 1'b1; od_p = i0.pkt; end
        else         begin ev_v = 1'b1; ev_p = i0.pkt; end
      end
      if (e1) begin
        if (i1.pipe) begin od_v = 1'b1; od_p = i1.pkt; end
        else         begin ev_v = 1'b1; ev_p = i1.pkt; end
      end

      @(posedge clk);
      if (rst) begin
        for (int r = 0; r < NUM_REGS; r++) rdy_cyc[r] = 0;
      end else begin
        if (e0 && i0.pkt.reg_wr && i0.pkt.latency != 0)
          rdy_cyc[i0.pkt.reg_dst] = cyc + int'(i0.pkt.latency) + 1;
        if (e1 && i1.pkt.reg_wr && i1.pkt.latency != 0)
          rdy_cyc[i1.pkt.reg_dst] = cyc + int'(i1.pkt.latency) + 1;
      end
      if (e0) void'(q.pop_front());
      if (e1) void'(q.pop_front());
      cyc++;
      #1;

      busy_exp = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) if (rdy_cyc[r] > cyc) busy_exp = 1'b1;
      chk("even_valid", even_valid, ev_v);
      chk("even_pkt",   even_pkt,   ev_p);
      chk("odd_valid",  odd_valid,  od_v);
      chk("odd_pkt",    odd_pkt,    od_p);
      chk("sb_busy",    sb_busy,    busy_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spu_issue_ctrl.md
Name: spu_issue_ctrl

Overview:
- Dual-issue stage that feeds the even/odd RF/FU pipe inputs. This is the producer side of the pipe input bundle.
- Accepts up to two decoded instructions per cycle in program order. Checks register hazards against a latency-countdown scoreboard and checks pipe conflicts.
- Drives registered even/odd issue packets (full_instr, instr_id, reg_dst, unit_id, latency, reg_wr, imme7/10/16/18, ra/rb/rc) into the pipe wrapper.

Parameters:
- PKT_W, 126, issue packet width (32+7+7+3+4+1+7+10+16+18+3*7).
- NUM_REGS, 128, architectural register count.
- LAT_W, 4, latency field width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in0_valid  in  1  oldest decoded instruction present
- in0_pkt  in  PKT_W  oldest instruction issue packet
- in0_pipe  in  1  target pipe, 0=even 1=odd
- in0_src_use  in  3  ra/rb/rc read-enable flags
- in1_valid  in  1  second instruction present
- in1_pkt  in  PKT_W  second instruction issue packet
- in1_pipe  in  1  target pipe
- in1_src_use  in  3  ra/rb/rc read-enable flags
- flush  in  1  discard un-issued inputs this cycle
- in_consume  out  2  instructions accepted this cycle (0/1/2), combinational
- even_valid  out  1  even packet valid, registered
- even_pkt  out  PKT_W  even pipe packet, registered
- odd_valid  out  1  odd packet valid, registered
- odd_pkt  out  PKT_W  odd pipe packet, registered
- sb_busy  out  1  any scoreboard counter nonzero, registered

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all NUM_REGS counters 0; even_valid=odd_valid=0; even_pkt=odd_pkt=0; sb_busy=0. in_consume is forced 0 while rst=1.
- Scoreboard: per-register LAT_W counter cnt[r].
  - Each edge, every nonzero counter decrements by 1.
  - On issue of an instruction with reg_wr=1 and latency>0, cnt[reg_dst] is loaded with latency; the load wins over the decrement for that register.
  - Latency 0 or reg_wr=0 leaves the scoreboard untouched.
- A source register is ready when cnt[src]==0. Only flagged sources (src_use) are checked.
- in0 issues iff all of:
  - in0_valid and !flush;
  - all used sources are ready;
  - if reg_wr, cnt[reg_dst]==0 (WAW).
- in1 issues iff all of:
  - in0 issues;
  - in1_valid;
  - in1_pipe != in0_pipe;
  - in1's own scoreboard checks pass;
  - no used in1 source equals in0 reg_dst when in0 reg_wr=1 (intra-pair RAW);
  - not both reg_wr with equal reg_dst.
- in1 never issues without in0 (in-order issue). The decoder shifts by in_consume; a stalled in1 is re-presented as in0.
- Latency: an instruction accepted in cycle t appears on *_valid/*_pkt in cycle t+1.
- The pipe not receiving an instruction gets valid=0 and pkt=all-zero (nop) on the next edge.
- flush: in_consume=0; both valids 0 next cycle; the scoreboard keeps counting in-flight results.
- Counter timing example: issued in cycle t with latency L, the counter reads L..1 over cycles t+1..t+L and reads 0 in cycle t+L+1. A dependent instruction issues in cycle t+L+1.
- Reset mid-stall clears the scoreboard; a stalled instruction re-presented after reset issues immediately.

Decomposition:
- Package spu_issue_pkg holds:
  - PKT_W and the field offsets/widths;
  - issue_pkt_t packed struct, field order full_instr, instr_id, reg_dst, unit_id, latency, reg_wr, imme7, imme10, imme16, imme18, ra, rb, rc;
  - pipe_sel_t enum EVEN/ODD.
- Sub-module spu_scoreboard:
  - counter array with decrement logic;
  - two load ports (even, odd);
  - six source-ready query ports plus two dst-ready query ports;
  - busy output.

Test Plan:
- Reset: hold rst 3 cycles with both inputs valid -> in_consume=0, even_valid=odd_valid=0, pkts all-zero, sb_busy=0.
- Dual issue: in0 even r1<-r2,r3 lat 2; in1 odd r4<-r5 lat 6 -> in_consume=2; next cycle even_pkt.reg_dst=1 and odd_pkt.reg_dst=4, both valid; sb_busy=1.
- Intra-pair RAW: in0 even r1 lat 3 at cycle t; in1 odd ra=1 -> in_consume=1 at t. in1 is re-presented as in0 and stalls t+1..t+3, issues at t+4, odd_valid=1 at t+5.
- Same-pipe conflict: both in0 and in1 even, independent -> in_consume=1, even_pkt=in0 next cycle; in1 issues the following cycle.
- WAW: in-flight r7 cnt=4, new in0 writes r7 -> stalls until cnt[7]=0, then issues; cnt[7] reloads with the new latency.
- Flush/reset mid-stall: flush during a RAW stall -> valids 0, scoreboard still decrements to 0. Separately, rst during a stall -> next non-reset cycle the re-presented instruction issues with in_consume=1.
